// File: rtl/coin_input_conditioner.sv
// Synchronizes and debounces raw vending-panel inputs and shapes coin/cancel strobes for the vending FSM.
// Define COIN_FIVE_EN to build the 5-yuan coin channel; without it btn_five is ignored.
module coin_input_conditioner #(
  parameter int DB_CYCLES = 500000,
  parameter int CNT_W     = 20,
  parameter int PULSE_W   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_half,
  input  logic       btn_one,
  input  logic       btn_five,
  input  logic       btn_cancel,
  input  logic [1:0] sw_drink,
  output logic       insert,
  output logic [1:0] coin_val,
  output logic       cancel_flag,
  output logic [1:0] drink_op,
  output logic       reject
);

`ifdef COIN_FIVE_EN
  localparam bit FIVE_EN = 1'b1;
`else
  localparam bit FIVE_EN = 1'b0;
`endif

  localparam int NCH  = 6;
  localparam int PC_W = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [PC_W-1:0]  PC_LAST = PC_W'(PULSE_W - 1);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, GAP} state_t;

  // Channel map: 0 half, 1 one, 2 five, 3 cancel, 5:4 drink switches.
  logic [NCH-1:0] raw;
  logic [NCH-1:0] lvl;

  assign raw = {sw_drink, btn_cancel, btn_five, btn_one, btn_half};

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    if (i == 2 && !FIVE_EN) begin : g_off
      logic unused_raw;
      assign unused_raw = raw[i];
      assign lvl[i]     = 1'b0;
    end else begin : g_on
      logic [1:0]       sync_q;
      logic             lvl_q, lvl_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;

      always_comb begin
        lvl_d = lvl_q;
        cnt_d = '0;
        if (sync_q[1] != lvl_q) begin
          if (cnt_q == DB_LAST) lvl_d = ~lvl_q;
          else                  cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_q <= '0;
          lvl_q  <= 1'b0;
          cnt_q  <= '0;
        end else begin
          sync_q <= {sync_q[0], raw[i]};
          lvl_q  <= lvl_d;
          cnt_q  <= cnt_d;
        end
      end

      assign lvl[i] = lvl_q;
    end
  end

  // Rising edges of the debounced button levels become one-cycle events.
  logic [3:0] prev_q, ev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      ev_q   <= '0;
    end else begin
      prev_q <= lvl[3:0];
      ev_q   <= lvl[3:0] & ~prev_q;
    end
  end

  assign drink_op = lvl[5:4];

  logic       multi_ev;
  logic [1:0] ev_code;

  assign multi_ev = (ev_q & (ev_q - 4'd1)) != 4'd0;

  always_comb begin
    ev_code = 2'b01;
    if (ev_q[2])      ev_code = 2'b11;
    else if (ev_q[1]) ev_code = 2'b10;
  end

  state_t          state_q;
  logic [PC_W-1:0] pcnt_q;
  logic            sel_cancel_q, insert_q, cancel_q, reject_q;
  logic [1:0]      coin_q;

  // coin_val is loaded on entry to SETUP so it leads the strobe by a full cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pcnt_q       <= '0;
      sel_cancel_q <= 1'b0;
      insert_q     <= 1'b0;
      cancel_q     <= 1'b0;
      reject_q     <= 1'b0;
      coin_q       <= 2'b00;
    end else begin
      reject_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|ev_q) begin
            state_q      <= SETUP;
            sel_cancel_q <= ev_q[3];
            reject_q     <= multi_ev;
            if (!ev_q[3]) coin_q <= ev_code;
          end
        end
        SETUP: begin
          state_q  <= PULSE;
          pcnt_q   <= '0;
          insert_q <= ~sel_cancel_q;
          cancel_q <= sel_cancel_q;
          reject_q <= |ev_q;
        end
        PULSE: begin
          reject_q <= |ev_q;
          if (pcnt_q == PC_LAST) begin
            insert_q <= 1'b0;
            cancel_q <= 1'b0;
            state_q  <= GAP;
            pcnt_q   <= '0;
          end else begin
            pcnt_q <= pcnt_q + 1'b1;
          end
        end
        GAP: begin
          reject_q <= |ev_q;
          if (pcnt_q == PC_LAST) state_q <= IDLE;
          else                   pcnt_q  <= pcnt_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign insert      = insert_q;
  assign cancel_flag = cancel_q;
  assign reject      = reject_q;
  assign coin_val    = coin_q;

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Scoreboard bench for coin_input_conditioner: a history-window reference model predicts strobes,
// coin codes, rejects and drink levels; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_coin_input_conditioner;
  localparam int DB   = 4;
  localparam int PW   = 2;
  localparam int MAXE = 8192;
`ifdef COIN_FIVE_EN
  localparam bit FIVE = 1'b1;
`else
  localparam bit FIVE = 1'b0;
`endif
  localparam logic [5:0] H = 6'b000001, O = 6'b000010, F = 6'b000100, C = 6'b001000;

  logic       clk = 1'b1;
  logic       rst_n = 1'b0;
  logic       btn_half = 1'b0, btn_one = 1'b0, btn_five = 1'b0, btn_cancel = 1'b0;
  logic [1:0] sw_drink = 2'b00;
  logic       insert, cancel_flag, reject;
  logic [1:0] coin_val, drink_op;

  coin_input_conditioner #(.DB_CYCLES(DB), .CNT_W(4), .PULSE_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .btn_half(btn_half), .btn_one(btn_one), .btn_five(btn_five),
    .btn_cancel(btn_cancel), .sw_drink(sw_drink), .insert(insert), .coin_val(coin_val),
    .cancel_flag(cancel_flag), .drink_op(drink_op), .reject(reject)
  );

  always #5 clk = ~clk;

  typedef struct { int e; logic [1:0] v; } item_t;
  item_t iq[$], cq[$], rq[$], coinq[$], dq[$];

  int checks = 0, fails = 0;
  int n = 0, rel_edge = 0, free_edge = 0;
  logic [5:0] raw_h [0:MAXE-1];
  logic [5:0] lvl_h [0:MAXE-1];
  logic [5:0] cur_raw = 6'd0;
  logic [1:0] model_coin = 2'b00;
  int ins_cnt = 0, can_cnt = 0, rej_cnt = 0, last_ins_rise = -1, last_coin_chg = -1;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", nm, act, exp, n);
    end
  endtask

  function automatic logic [5:0] raw_at(input int k);
    if (k < 0 || k < rel_edge) return 6'd0;
    return raw_h[k];
  endfunction

  function automatic logic [5:0] lvl_at(input int k);
    if (k < 0 || k < rel_edge) return 6'd0;
    return lvl_h[k];
  endfunction

  task automatic model_reset();
    rel_edge   = n + 1;
    free_edge  = 0;
    model_coin = 2'b00;
    raw_h[n]   = cur_raw;
    lvl_h[n]   = 6'd0;
    iq.delete(); cq.delete(); rq.delete(); coinq.delete(); dq.delete();
  endtask

  // A level follows its input once the last DB synchronized samples all disagree with it.
  task automatic model_step();
    logic [5:0] nl, prv, smp;
    logic [3:0] ev;
    item_t it;
    raw_h[n] = cur_raw;
    prv = lvl_at(n - 1);
    nl  = prv;
    for (int c = 0; c < 6; c++) begin
      automatic bit diff = 1'b1;
      for (int k = n - 1 - DB; k <= n - 2; k++) begin
        smp = raw_at(k);
        if (smp[c] == prv[c]) diff = 1'b0;
      end
      if (diff) nl[c] = ~prv[c];
    end
    if (!FIVE) nl[2] = 1'b0;
    lvl_h[n] = nl;
    if (nl[5:4] != prv[5:4]) begin
      it.e = n; it.v = nl[5:4]; dq.push_back(it);
    end
    smp = lvl_at(n - 2);
    ev  = prv[3:0] & ~smp[3:0];
    if (ev != 4'd0) begin
      if (n + 1 >= free_edge) begin
        free_edge = n + 3 + 2 * PW;
        it.e = n + 2;
        if (ev[3]) begin
          it.v = model_coin; cq.push_back(it);
        end else begin
          it.v = ev[2] ? 2'b11 : (ev[1] ? 2'b10 : 2'b01);
          iq.push_back(it);
          if (it.v != model_coin) begin
            item_t ch;
            ch.e = n + 1; ch.v = it.v; coinq.push_back(ch);
            model_coin = it.v;
          end
        end
        if ($countones(ev) > 1) begin
          it.e = n + 1; it.v = 2'b00; rq.push_back(it);
        end
      end else begin
        it.e = n + 1; it.v = 2'b00; rq.push_back(it);
      end
    end
  endtask

  task automatic step(input logic [5:0] r, input logic rn);
    @(negedge clk);
    {sw_drink, btn_cancel, btn_five, btn_one, btn_half} = r;
    rst_n   = rn;
    cur_raw = r;
    @(posedge clk);
    n++;
    if (!rst_n) model_reset();
    else        model_step();
  endtask

  // Monitor: pops expectations whenever the DUT presents an output change or pulse.
  initial begin
    logic pi, pc;
    logic [1:0] pcv, pd;
    int iw, cw;
    item_t it;
    pi = 1'b0; pc = 1'b0; pcv = 2'b00; pd = 2'b00; iw = 0; cw = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pi = 1'b0; pc = 1'b0; pcv = 2'b00; pd = 2'b00; iw = 0; cw = 0;
      end else begin
        if (coin_val !== pcv) begin
          check("coin_change_expected", int'(coinq.size() > 0), 1);
          if (coinq.size() > 0) begin
            it = coinq.pop_front();
            check("coin_change_edge", n, it.e);
            check("coin_change_val", int'(coin_val), int'(it.v));
          end
          last_coin_chg = n;
        end
        if (drink_op !== pd) begin
          check("drink_change_expected", int'(dq.size() > 0), 1);
          if (dq.size() > 0) begin
            it = dq.pop_front();
            check("drink_edge", n, it.e);
            check("drink_val", int'(drink_op), int'(it.v));
          end
        end
        if (reject) begin
          rej_cnt++;
          check("reject_expected", int'(rq.size() > 0), 1);
          if (rq.size() > 0) begin
            it = rq.pop_front();
            check("reject_edge", n, it.e);
          end
        end
        if (insert && !pi) begin
          ins_cnt++;
          last_ins_rise = n;
          check("insert_expected", int'(iq.size() > 0), 1);
          if (iq.size() > 0) begin
            it = iq.pop_front();
            check("insert_edge", n, it.e);
            check("insert_coin_val", int'(coin_val), int'(it.v));
            check("coin_val_setup", int'(pcv), int'(it.v));
          end
        end
        if (cancel_flag && !pc) begin
          can_cnt++;
          check("cancel_expected", int'(cq.size() > 0), 1);
          if (cq.size() > 0) begin
            it = cq.pop_front();
            check("cancel_edge", n, it.e);
            check("cancel_coin_kept", int'(coin_val), int'(it.v));
          end
        end
        if (!insert && pi) check("insert_width", iw, PW);
        if (!cancel_flag && pc) check("cancel_width", cw, PW);
        iw = insert ? iw + 1 : 0;
        cw = cancel_flag ? cw + 1 : 0;
        if (insert || cancel_flag) check("strobe_exclusive", int'(insert & cancel_flag), 0);
        pi = insert; pc = cancel_flag; pcv = coin_val; pd = drink_op;
      end
    end
  end

  initial begin
    int p, i0, c0, r0, hold[6];
    logic [5:0] rr;
    bit seen;

    for (int i = 0; i < 3; i++) step(6'd0, 1'b0);
    for (int i = 0; i < 20; i++) step(6'd0, 1'b1);
    #1;
    check("idle_insert", int'(insert), 0);
    check("idle_cancel", int'(cancel_flag), 0);
    check("idle_reject", int'(reject), 0);
    check("idle_coin_val", int'(coin_val), 0);
    check("idle_drink_op", int'(drink_op), 0);

    // Clean 1-yuan press held 10 cycles.
    i0 = ins_cnt; r0 = rej_cnt; p = n + 1;
    for (int i = 0; i < 10; i++) step(O, 1'b1);
    for (int i = 0; i < 20; i++) step(6'd0, 1'b1);
    check("one_coin_change_cycle", last_coin_chg, p + 7);
    check("one_insert_rise_cycle", last_ins_rise, p + 8);
    check("one_insert_count", ins_cnt - i0, 1);
    check("one_reject_count", rej_cnt - r0, 0);

    // Bouncing half button, then held.
    i0 = ins_cnt;
    for (int i = 0; i < 12; i++) step(((i / 2) % 2 == 0) ? H : 6'd0, 1'b1);
    for (int i = 0; i < 12; i++) step(H, 1'b1);
    for (int i = 0; i < 20; i++) step(6'd0, 1'b1);
    check("bounce_insert_count", ins_cnt - i0, 1);
    check("bounce_coin_val", int'(coin_val), 1);

    // Cancel and five rising together.
    i0 = ins_cnt; c0 = can_cnt; r0 = rej_cnt;
    for (int i = 0; i < 10; i++) step(C | F, 1'b1);
    for (int i = 0; i < 20; i++) step(6'd0, 1'b1);
    check("cf_cancel_count", can_cnt - c0, 1);
    check("cf_insert_count", ins_cnt - i0, 0);
    check("cf_reject_count", rej_cnt - r0, FIVE ? 1 : 0);
    check("cf_coin_val", int'(coin_val), 1);

    // Second coin debounced while the first strobe is in PULSE.
    i0 = ins_cnt; r0 = rej_cnt;
    for (int i = 0; i < 12; i++) step((i >= 2) ? (H | O) : H, 1'b1);
    for (int i = 0; i < 20; i++) step(6'd0, 1'b1);
    check("busy_insert_count", ins_cnt - i0, 1);
    check("busy_reject_count", rej_cnt - r0, 1);
    check("busy_coin_val", int'(coin_val), 1);

    // Reset while insert is high, button kept pressed through release.
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step(O, 1'b1);
      #1;
      if (insert) seen = 1'b1;
    end
    check("reset_insert_seen", int'(seen), 1);
    #1 rst_n = 1'b0;
    #1;
    check("reset_insert_async", int'(insert), 0);
    check("reset_cancel_async", int'(cancel_flag), 0);
    check("reset_coin_async", int'(coin_val), 0);
    for (int i = 0; i < 3; i++) step(O, 1'b0);
    p = n + 1;
    for (int i = 0; i < 20; i++) step(O, 1'b1);
    check("reset_reemit_cycle", last_ins_rise, p + 8);
    for (int i = 0; i < 20; i++) step(6'd0, 1'b1);

    // Randomized bouncing on every input.
    rr = 6'd0;
    for (int c = 0; c < 6; c++) hold[c] = 0;
    for (int t = 0; t < 1500; t++) begin
      for (int c = 0; c < 6; c++) begin
        if (hold[c] == 0) begin
          rr[c]   = 1'($urandom_range(0, 1));
          hold[c] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : int'($urandom_range(5, 14));
        end
        hold[c]--;
      end
      step(rr, 1'b1);
    end
    for (int i = 0; i < 40; i++) step(6'd0, 1'b1);
    check("drain_insert_q", iq.size(), 0);
    check("drain_cancel_q", cq.size(), 0);
    check("drain_reject_q", rq.size(), 0);
    check("drain_coin_q", coinq.size(), 0);
    check("drain_drink_q", dq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
